// File: rtl/ram_arbiter.sv
// Two-client arbiter sharing one RAM write port and one RAM read port, each with its own round-robin pointer.
// Optional write-to-read forwarding for same-cycle, same-address traffic: define RAM_ARB_WR_FWD_EN.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              c0_req,
    input  logic              c0_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_gnt,
    output logic              c0_rvalid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_req,
    input  logic              c1_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_gnt,
    output logic              c1_rvalid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [DATA_W-1:0] ram_write_data,
    output logic              ram_read_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    input  logic [DATA_W-1:0] ram_read_data
);

    logic [1:0]        wr_cand, rd_cand;
    logic [1:0]        wr_gnt, rd_gnt;
    logic              wr_ptr, rd_ptr;
    logic [1:0]        rvalid_q;
    logic [DATA_W-1:0] rdata_mux;

    // On contention the pointer names the winner; a lone candidate always wins.
    function automatic logic [1:0] pick(input logic [1:0] cand, input logic ptr);
        if (cand == 2'b11)
            return ptr ? 2'b10 : 2'b01;
        return cand;
    endfunction

    always_comb begin
        wr_cand = {c1_req & c1_we, c0_req & c0_we};
        rd_cand = {c1_req & ~c1_we, c0_req & ~c0_we};
        wr_gnt  = pick(wr_cand, wr_ptr) & {2{rst_n}};
        rd_gnt  = pick(rd_cand, rd_ptr) & {2{rst_n}};
    end

    assign c0_gnt = wr_gnt[0] | rd_gnt[0];
    assign c1_gnt = wr_gnt[1] | rd_gnt[1];

    assign ram_write_en   = |wr_gnt;
    assign ram_write_addr = wr_gnt[1] ? c1_addr  : c0_addr;
    assign ram_write_data = wr_gnt[1] ? c1_wdata : c0_wdata;
    assign ram_read_en    = |rd_gnt;
    assign ram_read_addr  = rd_gnt[1] ? c1_addr  : c0_addr;

    // Pointer moves to the client that lost (or did not ask) after every grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            if (|wr_gnt)
                wr_ptr <= wr_gnt[0];
            if (|rd_gnt)
                rd_ptr <= rd_gnt[0];
            rvalid_q <= rd_gnt;
        end
    end

`ifdef RAM_ARB_WR_FWD_EN
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data_q;

    // RAM returns the pre-write value on a same-address collision; substitute the written data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= ram_write_en & ram_read_en & (ram_write_addr == ram_read_addr);
            fwd_data_q <= ram_write_data;
        end
    end

    assign rdata_mux = fwd_q ? fwd_data_q : ram_read_data;
`else
    assign rdata_mux = ram_read_data;
`endif

    assign c0_rvalid = rvalid_q[0];
    assign c1_rvalid = rvalid_q[1];
    assign c0_rdata  = rdata_mux;
    assign c1_rdata  = rdata_mux;

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: directed vectors push expected grants and read returns,
// negedge monitor pops and compares. A behavioural registered RAM sits on the RAM ports.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       c0_req = 0, c0_we = 0, c1_req = 0, c1_we = 0;
    logic [7:0] c0_addr = 0, c1_addr = 0;
    logic [3:0] c0_wdata = 0, c1_wdata = 0;
    logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [3:0] c0_rdata, c1_rdata;
    logic       ram_write_en, ram_read_en;
    logic [7:0] ram_write_addr, ram_read_addr;
    logic [3:0] ram_write_data, ram_read_data;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [1:0] gnt;
        logic       wen;
        logic [7:0] waddr;
        logic [3:0] wdata;
        logic       ren;
        logic [7:0] raddr;
    } gexp_t;

    typedef struct {
        int         cl;
        logic [3:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    logic [3:0] mem [0:255];

    ram_arbiter #(.ADDR_W(8), .DATA_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
        .ram_write_en(ram_write_en), .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .ram_read_en(ram_read_en), .ram_read_addr(ram_read_addr),
        .ram_read_data(ram_read_data)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 4'h0;
        ram_read_data = 4'h0;
    end

    // Registered-read RAM: a same-cycle read sees the value before the write.
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_write_addr] <= ram_write_data;
        if (ram_read_en) ram_read_data <= mem[ram_read_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (c0_req || c1_req)) begin
            if (gq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL gnt_queue: grant seen with no expectation at %0t", $time);
            end else begin
                gexp_t e;
                e = gq.pop_front();
                chk("gnt", {30'd0, c1_gnt, c0_gnt}, {30'd0, e.gnt});
                chk("ram_write_en", {31'd0, ram_write_en}, {31'd0, e.wen});
                if (e.wen) chk("ram_write_addr_data", {20'd0, ram_write_addr, ram_write_data},
                               {20'd0, e.waddr, e.wdata});
                chk("ram_read_en", {31'd0, ram_read_en}, {31'd0, e.ren});
                if (e.ren) chk("ram_read_addr", {24'd0, ram_read_addr}, {24'd0, e.raddr});
            end
        end
        if (c0_rvalid || c1_rvalid) begin
            if (rq.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL rvalid_queue: rvalid c0=%0b c1=%0b with nothing expected at %0t",
                         c0_rvalid, c1_rvalid, $time);
            end else begin
                rexp_t r;
                r = rq.pop_front();
                chk("rvalid", {30'd0, c1_rvalid, c0_rvalid}, (r.cl == 1) ? 32'd2 : 32'd1);
                chk("rdata", {28'd0, (r.cl == 1) ? c1_rdata : c0_rdata}, {28'd0, r.data});
            end
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [3:0] d0,
                         input logic r1, input logic w1, input logic [7:0] a1, input logic [3:0] d1,
                         input logic [1:0] eg, input bit pulse = 1'b0);
        gexp_t e;
        c0_req = r0; c0_we = w0; c0_addr = a0; c0_wdata = d0;
        c1_req = r1; c1_we = w1; c1_addr = a1; c1_wdata = d1;
        e.gnt   = eg;
        e.wen   = (eg[0] && r0 && w0) || (eg[1] && r1 && w1);
        e.waddr = (eg[0] && r0 && w0) ? a0 : a1;
        e.wdata = (eg[0] && r0 && w0) ? d0 : d1;
        e.ren   = (eg[0] && r0 && !w0) || (eg[1] && r1 && !w1);
        e.raddr = (eg[0] && r0 && !w0) ? a0 : a1;
        gq.push_back(e);
        if (pulse) begin
            #6;
            rst_n = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        c0_req = 0; c1_req = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_r(input int cl, input logic [3:0] d);
        rexp_t r;
        r.cl = cl; r.data = d;
        rq.push_back(r);
    endtask

    initial begin
        logic [3:0] exp_fwd;
`ifdef RAM_ARB_WR_FWD_EN
        exp_fwd = 4'hF;
`else
        exp_fwd = 4'h1;
`endif
        c0_req = 1; c0_we = 0; c0_addr = 8'h07;
        c1_req = 1; c1_we = 1; c1_addr = 8'h08;
        #3;
        chk("rst_gnt", {30'd0, c1_gnt, c0_gnt}, 32'd0);
        chk("rst_ram_en", {30'd0, ram_write_en, ram_read_en}, 32'd0);
        chk("rst_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_rvalid_hold", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        c0_req = 0; c1_req = 0;
        rst_n = 1'b1;
        idle(1);

        // write then read back through the other client
        drive(1, 1, 8'h03, 4'hA, 0, 0, 8'h00, 4'h0, 2'b01);
        drive(0, 0, 8'h00, 4'h0, 1, 0, 8'h03, 4'h0, 2'b10); push_r(1, 4'hA);
        drive(1, 1, 8'h02, 4'h9, 0, 0, 8'h00, 4'h0, 2'b01);
        drive(1, 1, 8'h04, 4'h1, 0, 0, 8'h00, 4'h0, 2'b01);
        // concurrent write and read, different addresses
        drive(1, 1, 8'h05, 4'h6, 1, 0, 8'h02, 4'h0, 2'b11); push_r(1, 4'h9);
        // same-address collision
        drive(1, 1, 8'h04, 4'hF, 1, 0, 8'h04, 4'h0, 2'b11); push_r(1, exp_fwd);
        drive(1, 0, 8'h04, 4'h0, 0, 0, 8'h00, 4'h0, 2'b01); push_r(0, 4'hF);
        drive(0, 0, 8'h00, 4'h0, 1, 0, 8'h05, 4'h0, 2'b10); push_r(1, 4'h6);
        idle(2);

        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // write contention from a fresh pointer
        drive(1, 1, 8'h10, 4'h1, 1, 1, 8'h11, 4'h2, 2'b01);
        drive(1, 1, 8'h10, 4'h1, 1, 1, 8'h11, 4'h2, 2'b10);
        drive(1, 1, 8'h10, 4'h1, 1, 1, 8'h11, 4'h2, 2'b01);
        drive(1, 1, 8'h10, 4'h1, 1, 1, 8'h11, 4'h2, 2'b10);
        // read contention, loser retries next cycle
        drive(1, 0, 8'h10, 4'h0, 1, 0, 8'h11, 4'h0, 2'b01); push_r(0, 4'h1);
        drive(0, 0, 8'h00, 4'h0, 1, 0, 8'h11, 4'h0, 2'b10); push_r(1, 4'h2);
        drive(1, 1, 8'h20, 4'h3, 0, 0, 8'h00, 4'h0, 2'b01);

        // read granted, then reset held across the edge: the read must vanish
        drive(1, 0, 8'h10, 4'h0, 0, 0, 8'h00, 4'h0, 2'b01, 1'b1);
        chk("drop_rvalid", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);
        c0_req = 0; c1_req = 0;
        rst_n = 1'b1;
        idle(1);
        chk("drop_rvalid_after", {30'd0, c1_rvalid, c0_rvalid}, 32'd0);

        drive(1, 0, 8'h10, 4'h0, 1, 0, 8'h11, 4'h0, 2'b01); push_r(0, 4'h1);
        drive(1, 1, 8'h21, 4'h4, 1, 1, 8'h22, 4'h5, 2'b01);
        idle(3);

        chk("gq_empty", gq.size(), 32'd0);
        chk("rq_empty", rq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 4, RAM data width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cN_req  input  1  client N (N=0,1) access request.
REQ-006 cN_we  input  1  client N access type: 1 = write, 0 = read.
REQ-007 cN_addr  input  ADDR_W  client N address.
REQ-008 cN_wdata  input  DATA_W  client N write data.
REQ-009 cN_gnt  output  1  client N request accepted this cycle.
REQ-010 cN_rvalid  output  1  client N read data valid this cycle.
REQ-011 cN_rdata  output  DATA_W  client N read data, meaningful only while cN_rvalid=1.
REQ-012 ram_write_en, ram_write_addr, ram_write_data  output  1/ADDR_W/DATA_W  RAM write port.
REQ-013 ram_read_en, ram_read_addr  output  1/ADDR_W  RAM read port.
REQ-014 ram_read_data  input  DATA_W  RAM registered read data, valid one cycle after ram_read_en.

Function
REQ-015 Write port and read port SHALL be arbitrated independently; one write and one read SHALL be issued in the same cycle when both are requested.
REQ-016 Write candidates = clients with req=1, we=1; read candidates = clients with req=1, we=0.
REQ-017 Single candidate on a port SHALL be granted that cycle.
REQ-018 Two candidates on a port SHALL be resolved round-robin: grant the client named by that port's pointer (wr_ptr or rd_ptr).
REQ-019 After any grant on a port, that port's pointer SHALL point to the non-granted client; no grant leaves the pointer unchanged.
REQ-020 cN_gnt SHALL be combinational, same cycle as request; a denied client holds its request, and no request is queued internally.
REQ-021 Granted write SHALL drive ram_write_en=1 with the granted client's addr/wdata combinationally; no write grant drives ram_write_en=0.
REQ-022 Granted read SHALL drive ram_read_en=1 and ram_read_addr combinationally; no read grant drives ram_read_en=0.
REQ-023 Read latency SHALL be exactly 1 cycle: read granted at edge N -> cN_rvalid=1 for one cycle after edge N+1, only for the granted client.
REQ-024 cN_rdata SHALL equal ram_read_data, except as modified by REQ-031.
REQ-025 Back-to-back reads SHALL sustain one read per cycle with rvalid each cycle.
REQ-026 Addresses SHALL pass to the RAM unmodified; no range checking.
REQ-027 Same-cycle write and read to the same address without forwarding SHALL return the pre-write value.

Reset
REQ-028 rst_n=0 SHALL immediately clear c0_rvalid, c1_rvalid and the forwarding flag, and set wr_ptr=rd_ptr=client 0.
REQ-029 While rst_n=0, all grants and ram_write_en/ram_read_en SHALL be 0.
REQ-030 A read granted in the cycle reset asserts SHALL be dropped; no rvalid after reset release.

Configuration
REQ-031 With RAM_ARB_WR_FWD_EN defined: same-cycle write and read to equal addresses SHALL register the write data, and the next cycle's rdata SHALL return that data instead of ram_read_data.
REQ-032 Without RAM_ARB_WR_FWD_EN: no forwarding logic; REQ-027 applies.

Verification
REQ-033 Reset release, c0 write addr 3 data 0xA, then c1 read addr 3 -> c1_gnt same cycle, c1_rvalid next cycle, c1_rdata=0xA.
REQ-034 Both clients write every cycle for 4 cycles after reset -> grants alternate c0,c1,c0,c1; each denied client retries.
REQ-035 c0 writes addr 5 data 0x6 while c1 reads addr 2 (holding 0x9) -> both granted same cycle; next cycle c1_rdata=0x9.
REQ-036 Addr 4 holds 0x1; same cycle c0 writes addr 4 data 0xF, c1 reads addr 4 -> c1_rdata=0xF with RAM_ARB_WR_FWD_EN, 0x1 without.
REQ-037 Read granted, rst_n pulsed low before next edge -> c0_rvalid and c1_rvalid stay 0; next contention grants c0.
